// File: rtl/clint_rd_arbiter_if.sv
// AXI4-Lite read-channel bundle (AR + R) shared by the IFU, LSU and CLINT ports.
// Latency: none, wires only.
// Backpressure: carried by arready/rready in the usual valid/ready manner.
interface clint_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic              rvalid;
    logic              rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;

    // Seen from the side that issues reads.
    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    // Seen from the side that answers reads.
    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/clint_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter (IFU=m0, LSU=m1) in front of the CLINT, round-robin grant.
// Latency: request seen in IDLE -> s_arvalid next cycle; R handshake -> IDLE next cycle.
// Backpressure: one read outstanding; losing master sees arready=0 until the current read completes.
module clint_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    clint_rd_arbiter_if.slave    m0,
    clint_rd_arbiter_if.slave    m1,
    clint_rd_arbiter_if.master   s,
    output logic                 busy,
    output logic                 grant
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        AR   = 2'b01,
        R    = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   gnt_q, gnt_d;
    logic   last_q, last_d;

    // Request-side signals of whichever master currently holds the grant.
    logic              sel_arvalid;
    logic              sel_rready;
    logic [ADDR_W-1:0] sel_araddr;
    logic [DATA_W-1:0] rd_dat;
    logic [1:0]        rd_resp;

    assign sel_arvalid = gnt_q ? m1.arvalid : m0.arvalid;
    assign sel_rready  = gnt_q ? m1.rready  : m0.rready;
    assign sel_araddr  = gnt_q ? m1.araddr  : m0.araddr;

    // Returned data is only forwarded while the slave marks it valid, so idle buses read as zero.
    assign rd_dat  = s.rvalid ? s.rdata : '0;
    assign rd_resp = s.rvalid ? s.rresp : 2'b00;

    // State, grant and round-robin pointer; last starts at 1 so the first tie goes to m0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // Next-state: arbitrate in IDLE, wait for AR handshake, then wait for R handshake.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (m0.arvalid || m1.arvalid) begin
                    // On a tie the master not served last wins; otherwise the sole requester.
                    gnt_d   = (m0.arvalid && m1.arvalid) ? ~last_q : m1.arvalid;
                    state_d = AR;
                end
            end
            AR: begin
                // A granted master dropping arvalid just parks us here; no re-arbitration.
                if (sel_arvalid && s.arready) begin
                    state_d = R;
                end
            end
            R: begin
                if (s.rvalid && sel_rready) begin
                    last_d  = gnt_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output steering: connect only the granted master to the slave, everything else held at zero.
    always_comb begin
        s.arvalid  = 1'b0;
        s.araddr   = '0;
        s.rready   = 1'b0;
        m0.arready = 1'b0;
        m0.rvalid  = 1'b0;
        m0.rdata   = '0;
        m0.rresp   = 2'b00;
        m1.arready = 1'b0;
        m1.rvalid  = 1'b0;
        m1.rdata   = '0;
        m1.rresp   = 2'b00;
        case (state_q)
            AR: begin
                s.arvalid = sel_arvalid;
                s.araddr  = sel_araddr;
                if (gnt_q) begin
                    m1.arready = s.arready;
                end else begin
                    m0.arready = s.arready;
                end
            end
            R: begin
                s.rready = sel_rready;
                if (gnt_q) begin
                    m1.rvalid = s.rvalid;
                    m1.rdata  = rd_dat;
                    m1.rresp  = rd_resp;
                end else begin
                    m0.rvalid = s.rvalid;
                    m0.rdata  = rd_dat;
                    m0.rresp  = rd_resp;
                end
            end
            default: begin
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign grant = gnt_q;

endmodule

// File: doc/clint_rd_arbiter.md
Name: clint_rd_arbiter

Overview:
- Two-master, one-slave AXI4-Lite read-channel arbiter in front of the CLINT timer slave.
- M0 is the IFU fetch port and M1 is the LSU load port; S is the CLINT read interface.
- Exactly one transaction is outstanding at a time, and grant is round-robin so neither master starves.
- The arbiter passes address, data and response through unchanged. It adds no buffering beyond the grant register.

Parameters:
- ADDR_W, 32, address width of araddr on all ports
- DATA_W, 32, data width of rdata on all ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- m0_arvalid  in  1  M0 read-address valid
- m0_arready  out  1  M0 read-address ready
- m0_araddr  in  ADDR_W  M0 read address
- m0_rvalid  out  1  M0 read-data valid
- m0_rready  in  1  M0 read-data ready
- m0_rdata  out  DATA_W  M0 read data
- m0_rresp  out  2  M0 read response
- m1_* (arvalid, arready, araddr, rvalid, rready, rdata, rresp): same directions, widths and meanings as m0_*, for M1
- s_arvalid  out  1  slave read-address valid
- s_arready  in  1  slave read-address ready
- s_araddr  out  ADDR_W  slave read address
- s_rvalid  in  1  slave read-data valid
- s_rready  out  1  slave read-data ready
- s_rdata  in  DATA_W  slave read data
- s_rresp  in  2  slave read response
- busy  out  1  high in AR or R state
- grant  out  1  index of the current/last granted master

Behaviour:

State register and pointers:
- States: IDLE, AR, R, held in a 2-bit register.
- gnt: 1-bit registered index of the master being served.
- last: 1-bit index of the master served most recently.

Reset (rst=1 at a clock edge):
- state=IDLE, gnt=0, last=1.
- All valid/ready outputs are 0 from the cycle after reset onward; they are combinational from state.
- rdata/rresp outputs are 0 whenever the corresponding rvalid=0.
- Reset mid-transaction aborts to IDLE. The slave is expected to be reset by the same rst.

IDLE:
- All arready, rvalid, s_arvalid and s_rready outputs are 0.
- If m0_arvalid or m1_arvalid: gnt <= winner, state <= AR.
- Winner selection:
  - Only one requesting: that master wins.
  - Both requesting: the master != last wins, so the first contention after reset goes to M0.
- No request: remain in IDLE.

AR:
- s_arvalid = m[gnt]_arvalid, s_araddr = m[gnt]_araddr, m[gnt]_arready = s_arready.
- The non-granted master sees arready=0.
- When s_arvalid & s_arready: state <= R.
- A granted master dropping arvalid before the handshake is a protocol violation. The arbiter stays in AR and does not re-arbitrate.

R:
- m[gnt]_rvalid = s_rvalid, m[gnt]_rdata = s_rdata, m[gnt]_rresp = s_rresp, s_rready = m[gnt]_rready.
- The other master sees rvalid=0.
- When s_rvalid & s_rready: last <= gnt, state <= IDLE.
- No arready is given to any master in R: there is strictly one outstanding transaction.

Latency and throughput:
- Request seen in IDLE at cycle N gives s_arvalid=1 at N+1.
- R handshake at cycle M gives IDLE at M+1; the earliest next s_arvalid is M+2.
- A waiting master's arvalid must stay asserted; it is served after the current transaction completes, and by round-robin before any re-request from the other master.
- Data and response values are passed untouched, with no width conversion.
- busy = (state != IDLE); grant = gnt.

Test Plan:
1. Single master: M0 reads 0x0200BFF8 with the slave returning 0x00000123/OKAY → s_araddr=0x0200BFF8 one cycle after m0_arvalid; m0_rdata=0x00000123, m0_rresp=0; m1 outputs stay 0 throughout.
2. Simultaneous first request after reset: M0 and M1 assert in the same cycle → M0 served first (grant=0), then M1 (grant=1) with no intervening IDLE→AR for M0. Each master receives only its own rdata (0xAAAA0000 vs 0xBBBB0000).
3. Fairness: M0 and M1 keep arvalid high for 6 transactions → grant sequence 0,1,0,1,0,1.
4. Backpressure: slave holds s_arready=0 for 3 cycles and M1 holds rready=0 for 4 cycles after rvalid → arbiter stays in AR, then in R. s_rready mirrors m1_rready, and m1_rdata stays stable until the handshake.
5. Reset mid-transaction: assert rst while in R → next cycle state=IDLE, all valid/ready outputs 0, busy=0. The first post-reset contention is granted to M0.
6. Back-to-back single master: M1 reissues arvalid immediately after its R handshake at cycle M → next s_arvalid at cycle M+2; busy is 0 exactly during cycle M+1.
